// File: rtl/sd_seq_pkg.sv
// Shared definitions for the srdy/drdy sequence source and its matching checker.
// Both ends import this so they agree on state encoding and the slot-free rule.
package sd_seq_pkg;

  localparam int default_cnt_w = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // The pattern pointer advances only when the output slot can take a new word:
  // nothing is pending, or the pending word is accepted at this edge.
  function automatic logic slot_free(input logic srdy, input logic drdy);
    return !srdy || drdy;
  endfunction

endpackage

// File: rtl/sd_seq_source.sv
// Producer-side traffic source: emits an incrementing data sequence on srdy/drdy,
// gating p_srdy with a per-run pattern to produce bursty, gapped traffic.
module sd_seq_source
  import sd_seq_pkg::*;
#(
  parameter int width   = 8,
  parameter int pat_dep = 8,
  parameter int cnt_w   = default_cnt_w
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_w-1:0]   count,
  input  logic [width-1:0]   init_value,
  input  logic [pat_dep-1:0] srdy_pat,
  output logic               busy,
  output logic               done,
  output logic [cnt_w-1:0]   sent_cnt,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data
);

  localparam int dpp_w = (pat_dep > 1) ? $clog2(pat_dep) : 1;

  seq_state_t         state_reg, state_next;
  logic [cnt_w-1:0]   remaining_reg, remaining_next;
  logic [width-1:0]   seq_data_reg, seq_data_next;
  logic [pat_dep-1:0] pat_reg, pat_next;
  logic [dpp_w-1:0]   dpp_reg, dpp_next;
  logic               srdy_reg, srdy_next;
  logic [width-1:0]   data_reg, data_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [cnt_w-1:0]   sent_reg, sent_next;
  logic               xfer;

  assign xfer = srdy_reg & p_drdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      seq_data_reg  <= '0;
      pat_reg       <= '0;
      dpp_reg       <= '0;
      srdy_reg      <= 1'b0;
      data_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sent_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      seq_data_reg  <= seq_data_next;
      pat_reg       <= pat_next;
      dpp_reg       <= dpp_next;
      srdy_reg      <= srdy_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      sent_reg      <= sent_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    seq_data_next  = seq_data_reg;
    pat_next       = pat_reg;
    dpp_next       = dpp_reg;
    srdy_next      = srdy_reg;
    data_next      = data_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    sent_next      = sent_reg + cnt_w'(xfer);

    case (state_reg)
      IDLE: begin
        if (start) begin
          sent_next = '0;
          if (count != '0) begin
            remaining_next = count;
            seq_data_next  = init_value;
            // An all-zero pattern would stall forever; treat it as always-on.
            pat_next       = (srdy_pat == '0) ? '1 : srdy_pat;
            dpp_next       = '0;
            busy_next      = 1'b1;
            state_next     = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      RUN: begin
        if (slot_free(srdy_reg, p_drdy)) begin
          dpp_next = (dpp_reg == dpp_w'(pat_dep - 1)) ? '0 : dpp_reg + dpp_w'(1);
          if (remaining_reg != '0) begin
            if (pat_reg[dpp_reg]) begin
              srdy_next      = 1'b1;
              data_next      = seq_data_reg;
              seq_data_next  = seq_data_reg + width'(1);
              remaining_next = remaining_reg - cnt_w'(1);
            end else begin
              srdy_next = 1'b0;
            end
          end else begin
            srdy_next  = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign sent_cnt = sent_reg;
  assign p_srdy   = srdy_reg;
  assign p_data   = data_reg;

endmodule

// File: doc/sd_seq_source.md
# sd_seq_source

Producer-side traffic source for srdy/drdy testbenches. On a start pulse it emits a programmable number of words carrying an incrementing data sequence from a programmable initial value. It throttles its own p_srdy with a per-run pattern so consumer-side checkers see bursty, gapped traffic. It sits on the producer port of a block under test, opposite the team's sequence checker on the consumer port.

## Interface
- width, 8, data word width
- pat_dep, 8, srdy pattern depth in bits
- cnt_w, 16, width of word count and sent counter

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle run request; honoured only in IDLE
- count  input  cnt_w  words to send; sampled with start
- init_value  input  width  first data word; sampled with start
- srdy_pat  input  pat_dep  srdy gating pattern; sampled with start
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at run completion
- sent_cnt  output  cnt_w  words transferred in current/last run
- p_srdy  output  1  producer valid
- p_drdy  input  1  consumer ready
- p_data  output  width  producer data

## Operation
- States: IDLE, RUN.
- Reset (reset low, asynchronous): state IDLE; p_srdy 0, p_data 0, busy 0, done 0, sent_cnt 0; internal remaining, next_data, pattern pointer dpp and latched pattern cleared.
- IDLE + start, count>0: latch count into remaining, init_value into next_data, srdy_pat into pat; dpp←0, sent_cnt←0, busy←1, go to RUN.
- IDLE + start, count=0: done←1 for one cycle, sent_cnt←0, stay IDLE, busy stays 0.
- All-zero srdy_pat is latched as all ones; a run always makes progress.
- Start while in RUN is ignored.
- Transfer = p_srdy & p_drdy at a rising edge. Each transfer increments sent_cnt.
- Slot free = !p_srdy | p_drdy. In RUN, on a slot-free cycle:
  - dpp ← (dpp+1) mod pat_dep.
  - If remaining>0 and pat[dpp]=1: p_srdy←1, p_data←next_data, next_data←next_data+1 (wraps mod 2^width), remaining−1.
  - If remaining>0 and pat[dpp]=0: p_srdy←0.
  - If remaining=0: p_srdy←0, busy←0, done←1, go to IDLE.
- When the slot is not free (p_srdy=1, p_drdy=0): p_srdy and p_data hold stable, and dpp holds.
- p_srdy, once raised, never drops before a transfer.

## Timing
- All outputs are registered. There is no combinational path from p_drdy to any output.
- Start sampled at edge E0: RUN from E0. The earliest p_srdy is after E1.
- With pat all ones and p_drdy held 1: one word per cycle.
  - Word k is presented after edge Ek and transferred at edge E(k+1).
  - done pulses, and busy falls, in the cycle after the final transfer. N words take N+2 cycles from start to done.
- done is a single cycle wide. sent_cnt holds its final value until the next accepted start.
- Reset mid-run aborts immediately: p_srdy drops asynchronously and no done is issued.

## Structure
- A shared package sd_seq_pkg holds:
  - the state encoding (IDLE, RUN);
  - the default cnt_w;
  - the pattern-pointer advance rule (free slot = !srdy | drdy).
- The sequence checker reuses the same package so both ends agree on the rule.
- Single module; no sub-module warranted.

## Test plan
- count=4, init_value=8'hFE, pat=8'hFF, p_drdy=1 → p_data FE,FF,00,01 on consecutive cycles; done after 6 cycles; sent_cnt=4.
- count=3, pat=8'b0000_0101, p_drdy=1 → p_srdy pattern 1,0,1,0,0,0,0,0,1; data 0,1,2; done once.
- count=2, p_drdy low for 5 cycles while p_srdy=1 → p_data stable; no second word; dpp frozen; both words eventually arrive in order.
- count=0 start → done pulse next cycle; busy never rises; p_srdy stays 0. Start during RUN → ignored; sent_cnt unaffected.
- Reset asserted mid-run after 2 of 10 words → all outputs 0 immediately. A new start with init_value=8'h10 sends 10 from 8'h10.
- pat=0 with count=5 → behaves as all ones: 5 back-to-back words.
